// File: rtl/prog_end_dumper.sv
// rtl/prog_end_dumper.sv - halts the core at program end (or watchdog) and streams a data-memory window out.
module prog_end_dumper #(
    parameter logic [31:0] END_PC         = 32'h80,
    parameter int          BASE_WORD      = 32,
    parameter int          NUM_WORDS      = 96,
    parameter int          WORDS_PER_LINE = 16,
    parameter int          MAX_CYCLES     = 0,
    parameter int          ADDR_W         = 10,
    parameter int          DATA_W         = 32
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              EN,
    input  logic [31:0]       PCF,
    output logic              DM_RE,
    output logic [ADDR_W-1:0] DM_ADDR,
    input  logic [DATA_W-1:0] DM_RDATA,
    output logic              HALT,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_EOL,
    output logic              OUT_LAST,
    output logic              DONE,
    output logic              TIMEOUT,
    output logic [31:0]       CYCLES
);

    localparam bit                WD_ON     = (MAX_CYCLES != 0);
    localparam logic [31:0]       WD_LIMIT  = 32'(MAX_CYCLES - 1);
    localparam logic [31:0]       LAST_IDX  = 32'(NUM_WORDS - 1);
    localparam logic [31:0]       LINE_LAST = 32'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);

    typedef enum logic [2:0] {
        RUN  = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [31:0]       idx, idx_n;
    logic [31:0]       line_pos, line_pos_n;
    logic [31:0]       cycles_q, cycles_n;
    logic              timeout_q, timeout_n;
    logic [DATA_W-1:0] data_q, data_n;

    logic is_last;
    logic line_end;

    // line_pos tracks (idx mod WORDS_PER_LINE) incrementally so no divider is needed
    assign is_last  = (idx == LAST_IDX);
    assign line_end = (line_pos == LINE_LAST);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= RUN;
            idx       <= '0;
            line_pos  <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            line_pos  <= line_pos_n;
            cycles_q  <= cycles_n;
            timeout_q <= timeout_n;
            data_q    <= data_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        line_pos_n = line_pos;
        cycles_n   = cycles_q;
        timeout_n  = timeout_q;
        data_n     = data_q;
        case (state)
            RUN: begin
                if (EN) begin
                    if (cycles_q != 32'hFFFF_FFFF) begin
                        cycles_n = cycles_q + 32'd1;
                    end
                    // a PC match takes priority over a coincident watchdog expiry
                    if (PCF == END_PC) begin
                        state_n = READ;
                    end else if (WD_ON && (cycles_q == WD_LIMIT)) begin
                        state_n   = READ;
                        timeout_n = 1'b1;
                    end
                end
            end
            READ: begin
                state_n = CAPT;
            end
            CAPT: begin
                data_n  = DM_RDATA;
                state_n = SEND;
            end
            SEND: begin
                if (OUT_READY) begin
                    if (is_last) begin
                        state_n = FIN;
                    end else begin
                        idx_n      = idx + 32'd1;
                        line_pos_n = line_end ? 32'd0 : line_pos + 32'd1;
                        state_n    = READ;
                    end
                end
            end
            FIN: begin
                state_n = FIN;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    assign HALT      = (state != RUN);
    assign DM_RE     = (state == READ);
    assign DM_ADDR   = (state == READ) ? (BASE_ADDR + idx[ADDR_W-1:0]) : '0;
    assign OUT_VALID = (state == SEND);
    assign OUT_DATA  = data_q;
    assign OUT_EOL   = (state == SEND) && (line_end || is_last);
    assign OUT_LAST  = (state == SEND) && is_last;
    assign DONE      = (state == FIN);
    assign TIMEOUT   = timeout_q;
    assign CYCLES    = cycles_q;

endmodule

// File: doc/prog_end_dumper.md
PROG_END_DUMPER -- requirements
Module: prog_end_dumper

Interface
REQ-001 The block SHALL take parameter END_PC, default 32'h80: PC value that marks program end.
REQ-002 The block SHALL take parameter BASE_WORD, default 32: first data-memory word index dumped.
REQ-003 The block SHALL take parameter NUM_WORDS, default 96: number of words dumped (1 or more).
REQ-004 The block SHALL take parameter WORDS_PER_LINE, default 16: words between end-of-line marks (1 or more).
REQ-005 The block SHALL take parameter MAX_CYCLES, default 0: watchdog limit in enabled cycles; 0 disables the watchdog.
REQ-006 The block SHALL take parameter ADDR_W, default 10, and DATA_W, default 32: memory word-address and data widths.
REQ-007 The block SHALL have ports: CLK in 1, clock (all state on rising edge); CLR in 1, reset, asynchronous and active-high.
REQ-008 The block SHALL have ports: EN in 1, arm/count enable; PCF in 32, fetch-stage PC of the core.
REQ-009 The block SHALL have ports: DM_RE out 1, memory read strobe; DM_ADDR out ADDR_W, word address; DM_RDATA in DATA_W, read data valid the cycle after DM_RE.
REQ-010 The block SHALL have ports: HALT out 1, core stall request; OUT_VALID out 1; OUT_READY in 1; OUT_DATA out DATA_W; OUT_EOL out 1; OUT_LAST out 1.
REQ-011 The block SHALL have ports: DONE out 1; TIMEOUT out 1; CYCLES out 32, enabled-cycle count.

Function
REQ-012 The FSM SHALL have states RUN, READ, CAPT, SEND, FIN.
REQ-013 In RUN, when EN=1, CYCLES SHALL increment each cycle, saturating at 32'hFFFFFFFF; when EN=0, CYCLES holds and no trigger fires.
REQ-014 In RUN with EN=1, PCF==END_PC at a rising edge SHALL trigger: next state READ, HALT=1, TIMEOUT stays 0.
REQ-015 In RUN with EN=1, MAX_CYCLES!=0 and CYCLES==MAX_CYCLES-1 SHALL trigger likewise, setting TIMEOUT=1.
REQ-016 When a PC match and the watchdog coincide in the same cycle, the PC match SHALL win and TIMEOUT SHALL stay 0.
REQ-017 HALT SHALL be 1 in every state except RUN and SHALL stay 1 until reset; EN and PCF SHALL be ignored after the trigger.
REQ-018 In READ, the block SHALL drive DM_RE=1 and DM_ADDR=(BASE_WORD+idx) mod 2^ADDR_W, then go to CAPT; DM_RE SHALL be 0 in all other states.
REQ-019 In CAPT, the block SHALL register DM_RDATA into OUT_DATA and go to SEND.
REQ-020 In SEND, OUT_VALID SHALL be 1, and OUT_DATA, OUT_EOL and OUT_LAST SHALL be stable until the cycle OUT_READY=1.
REQ-021 On a SEND handshake, if idx==NUM_WORDS-1 the FSM SHALL go to FIN; otherwise idx SHALL increment and the FSM SHALL go to READ.
REQ-022 OUT_EOL SHALL be 1 when (idx+1) mod WORDS_PER_LINE==0 or idx==NUM_WORDS-1; OUT_LAST SHALL be 1 only when idx==NUM_WORDS-1.
REQ-023 The minimum cost SHALL be 3 cycles per word; OUT_READY held low SHALL stall indefinitely with no loss or duplication of words.
REQ-024 In FIN, DONE SHALL be 1, OUT_VALID SHALL be 0, CYCLES SHALL be frozen, and the FSM SHALL stay in FIN until reset.

Reset
REQ-025 CLR=1 SHALL immediately force state RUN, idx=0, CYCLES=0, and HALT, DM_RE, OUT_VALID, OUT_EOL, OUT_LAST, DONE, TIMEOUT=0, DM_ADDR=0, OUT_DATA=0.
REQ-026 CLR asserted mid-dump SHALL abort the dump with no further handshake; after release, counting SHALL restart from 0.

Verification
REQ-027 Defaults, memory word k holds k, OUT_READY=1, PCF reaches 0x80 -> 96 words 32..127 in order, EOL after words 47, 63, ..., 127, LAST on 127, DONE=1, TIMEOUT=0.
REQ-028 OUT_READY toggled randomly -> the same 96-word sequence with no duplicates, and OUT_DATA stable while OUT_VALID=1 and OUT_READY=0.
REQ-029 MAX_CYCLES=50, PCF never 0x80 -> trigger when CYCLES=49, TIMEOUT=1, HALT=1, full dump follows.
REQ-030 MAX_CYCLES=50, PCF=0x80 exactly when CYCLES=49 -> TIMEOUT=0, dump proceeds.
REQ-031 EN=0 for 10 cycles with PCF=0x80 -> no trigger and CYCLES unchanged; EN=1 -> trigger on the next edge.
REQ-032 CLR pulsed during word 40 of the dump -> all outputs 0 at once; rerun -> complete dump from word 32.
